// File: rtl/evt_stream_merger_pkg.sv
// sne_evt_pkg: shared index-width helper and merge status type for event-stream blocks
package sne_evt_pkg;
  localparam int STATUS_IDX_W = 8;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic                    busy;
    logic [STATUS_IDX_W-1:0] src_idx;
  } merge_status_t;
endpackage

// File: rtl/evt_stream_merger_if.sv
// SNE_EVENT_STREAM: valid/ready event stream carrying a payload of type T
// src: producer side (drives evt, valid; takes ready); dst: consumer side (the reverse)
interface SNE_EVENT_STREAM #(parameter type T = logic) ();
  T     evt;
  logic valid;
  logic ready;
  modport src (output evt, valid, input ready);
  modport dst (input evt, valid, output ready);
endinterface

// File: rtl/evt_stream_merger_arb.sv
// evt_merge_rr_arb: round-robin arbiter with burst hold for the event merger
// req_i: per-port requests; hs_i: a grant was accepted this cycle
// grant_o: one-hot grant (zero when nothing requests); gidx_o: granted port index
module evt_merge_rr_arb #(
  parameter int SRC_PORTS = 4,
  parameter int MAX_BURST = 1,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SRC_PORTS-1:0] req_i,
  input  logic                 hs_i,
  output logic [SRC_PORTS-1:0] grant_o,
  output logic [IDX_WIDTH-1:0] gidx_o
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(SRC_PORTS - 1);
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d, owner_q, owner_d, scan_j;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold;
  assign hold = req_i[owner_q] & (cnt_q < MAXB);
  // Scan downward so the last hit is the first requester at or after ptr.
  always_comb begin
    scan_j = '0;
    gidx_o = ptr_q;
    for (int i = SRC_PORTS - 1; i >= 0; i--) begin
      scan_j = IDX_WIDTH'((int'(ptr_q) + i) % SRC_PORTS);
      gidx_o = req_i[scan_j] ? scan_j : gidx_o;
    end
    gidx_o = hold ? owner_q : gidx_o;
    grant_o = (|req_i) ? SRC_PORTS'(1) << gidx_o : '0;
  end
  // A re-grant after burst expiry starts a fresh burst at 1.
  always_comb begin
    ptr_d = hs_i ? ((gidx_o == LAST) ? '0 : gidx_o + 1'b1) : ptr_q;
    owner_d = hs_i ? gidx_o : owner_q;
    cnt_d = !hs_i ? cnt_q : (gidx_o == owner_q && cnt_q < MAXB) ? cnt_q + 1'b1 : CW'(1);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/evt_stream_merger.sv
// evt_stream_merger: round-robin merge of SRC_PORTS event streams into one registered output
// enable_i: per-port enable; evt_stream_dst: input streams; evt_stream_src: merged stream
// src_idx_o: source port of the output event; busy_o: output held or enabled input pending
module evt_stream_merger
  import sne_evt_pkg::*;
#(
  parameter type T = logic,
  parameter int SRC_PORTS = 4,
  parameter int MAX_BURST = 1,
  localparam int IDX_WIDTH = idx_width(SRC_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SRC_PORTS-1:0] enable_i,
  SNE_EVENT_STREAM.dst         evt_stream_dst [SRC_PORTS],
  SNE_EVENT_STREAM.src         evt_stream_src,
  output logic [IDX_WIDTH-1:0] src_idx_o,
  output logic                 busy_o
);
  logic [SRC_PORTS-1:0] valid_in, req, grant;
  T evt_in [SRC_PORTS];
  T evt_q, evt_d;
  logic [IDX_WIDTH-1:0] gidx, idx_q, idx_d;
  logic valid_q, valid_d, load, hs;
  // Readys are masked by reset so nothing is accepted while the block is held.
  for (genvar k = 0; k < SRC_PORTS; k++) begin : g_in
    assign valid_in[k] = evt_stream_dst[k].valid;
    assign evt_in[k] = evt_stream_dst[k].evt;
    assign evt_stream_dst[k].ready = load & grant[k] & !rst_i;
  end
  assign req = valid_in & enable_i;
  assign load = !valid_q | evt_stream_src.ready;
  assign hs = load & (|req) & !rst_i;
  evt_merge_rr_arb #(
    .SRC_PORTS(SRC_PORTS),
    .MAX_BURST(MAX_BURST),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req),
    .hs_i   (hs),
    .grant_o(grant),
    .gidx_o (gidx)
  );
  always_comb begin
    valid_d = load ? |req : valid_q;
    evt_d = hs ? evt_in[gidx] : evt_q;
    idx_d = hs ? gidx : idx_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      evt_q <= '0;
      idx_q <= '0;
    end else begin
      valid_q <= valid_d;
      evt_q <= evt_d;
      idx_q <= idx_d;
    end
  end
  assign evt_stream_src.valid = valid_q;
  assign evt_stream_src.evt = evt_q;
  assign src_idx_o = idx_q;
  assign busy_o = valid_q | (|req);
endmodule

// File: tb/tb_evt_stream_merger.sv
// tb_evt_stream_merger: randomized and directed scoreboard bench for evt_stream_merger
module tb_evt_stream_merger;
  localparam int S = 4;
  localparam int MB = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [S-1:0] en, vld, rdy;
  logic [7:0] evt_v [S];
  logic ordy;
  logic [1:0] src_idx;
  logic busy;
  SNE_EVENT_STREAM #(.T(logic [7:0])) in_if [S] ();
  SNE_EVENT_STREAM #(.T(logic [7:0])) out_if ();
  for (genvar k = 0; k < S; k++) begin : g_if
    assign in_if[k].valid = vld[k];
    assign in_if[k].evt = evt_v[k];
    assign rdy[k] = in_if[k].ready;
  end
  assign out_if.ready = ordy;
  evt_stream_merger #(.T(logic [7:0]), .SRC_PORTS(S), .MAX_BURST(MB)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(en),
    .evt_stream_dst(in_if),
    .evt_stream_src(out_if),
    .src_idx_o(src_idx),
    .busy_o(busy)
  );
  int errors = 0;
  int checks = 0;
  int m_owner, m_cnt, m_ptr;
  bit m_full;
  int seq [S];
  int waitc [S];
  logic [9:0] exp_q [$];
  int obs_q [$];
  int exp_seq [$];
  bit hold;
  logic [9:0] held;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_owner = 0;
    m_cnt = 0;
    m_ptr = 0;
    m_full = 0;
    exp_q.delete();
    for (int k = 0; k < S; k++) waitc[k] = 0;
  endtask
  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic step(input logic [S-1:0] want, input logic o);
    int g;
    logic [S-1:0] req, exp_rdy;
    bit ld;
    for (int k = 0; k < S; k++)
      if (!vld[k] && want[k]) begin
        vld[k] = 1'b1;
        evt_v[k] = {2'(k), 6'(seq[k])};
        seq[k]++;
      end
    ordy = o;
    #1;
    req = vld & en;
    ld = !m_full || o;
    g = -1;
    if (!rst && ld && |req) begin
      if (req[m_owner] && m_cnt < MB) g = m_owner;
      else for (int i = S - 1; i >= 0; i--) if (req[(m_ptr + i) % S]) g = (m_ptr + i) % S;
    end
    exp_rdy = (g >= 0) ? S'(1) << g : '0;
    chk("ready", rdy, exp_rdy);
    chk("busy", busy, m_full || (|req));
    if (|(rdy & vld))
      for (int k = 0; k < S; k++) begin
        if (rdy[k]) waitc[k] = 0;
        else if (req[k]) begin
          waitc[k]++;
          chk("fair_wait", waitc[k] <= (S - 1) * MB, 1);
        end else waitc[k] = 0;
      end
    if (g >= 0) begin
      exp_q.push_back({2'(g), evt_v[g]});
      m_cnt = (g == m_owner && m_cnt < MB) ? m_cnt + 1 : 1;
      m_owner = g;
      m_ptr = (g + 1) % S;
    end
    if (!rst && ld) m_full = (g >= 0);
    @(posedge clk);
    #1;
    if (g >= 0) vld[g] = 1'b0;
  endtask
  task automatic reset_dut(input logic [S-1:0] want);
    rst = 1'b1;
    vld = '0;
    #1;
    chk("rst_valid", out_if.valid, 0);
    chk("rst_idx", src_idx, 0);
    chk("rst_evt", out_if.evt, 0);
    chk("rst_ready", rdy, 0);
    model_reset();
    step(want, 1'b1);
    step(want, 1'b1);
    rst = 1'b0;
    obs_q.delete();
  endtask
  task automatic seq_chk(input string name);
    chk({name, "_len"}, obs_q.size() >= exp_seq.size(), 1);
    for (int i = 0; i < exp_seq.size() && i < obs_q.size(); i++) chk(name, obs_q[i], exp_seq[i]);
  endtask
  always @(negedge clk) begin
    if (rst) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", out_if.valid, 1);
        chk("hold_data", {src_idx, out_if.evt}, held);
      end
      if (out_if.valid && ordy) begin
        chk("extra_out", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_data", {src_idx, out_if.evt}, exp_q.pop_front());
        obs_q.push_back(int'(src_idx));
      end
      hold = out_if.valid && !ordy;
      held = {src_idx, out_if.evt};
    end
  end
  initial begin
    bit found;
    en = '1;
    vld = '0;
    ordy = 1'b0;
    for (int k = 0; k < S; k++) begin
      evt_v[k] = '0;
      seq[k] = 0;
    end
    model_reset();
    @(posedge clk);
    #1;
    chk("init_valid", out_if.valid, 0);
    chk("init_idx", src_idx, 0);
    chk("init_ready", rdy, 0);
    reset_dut(4'b0101);
    step(4'b0101, 1'b1);
    chk("first_valid", out_if.valid, 1);
    repeat (9) step(4'b0101, 1'b1);
    exp_seq = {0, 0, 0, 2, 2, 2, 0, 0, 0};
    seq_chk("burst02");
    reset_dut('0);
    repeat (9) step(4'b0010, 1'b1);
    chk("solo_count", obs_q.size(), 8);
    exp_seq = {1, 1, 1, 1, 1, 1, 1, 1};
    seq_chk("solo1");
    reset_dut('0);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    repeat (5) begin
      step(4'b0010, 1'b0);
      chk("bp_valid", out_if.valid, 1);
      chk("bp_idx", src_idx, 1);
    end
    repeat (3) step(4'b0010, 1'b1);
    chk("bp_nogap", obs_q.size(), 4);
    en = 4'b1011;
    reset_dut('0);
    repeat (13) step('1, 1'b1);
    exp_seq = {0, 0, 0, 1, 1, 1, 3, 3, 3, 0, 0, 0};
    seq_chk("mask");
    obs_q.delete();
    en = '1;
    repeat (12) step('1, 1'b1);
    found = 0;
    for (int i = 0; i < obs_q.size() && i < 11; i++) if (obs_q[i] == 2) found = 1;
    chk("en2_grant", found, 1);
    reset_dut('0);
    repeat (3) step(4'b1000, 1'b0);
    chk("p3_valid", out_if.valid, 1);
    chk("p3_idx", src_idx, 3);
    reset_dut('1);
    repeat (6) step('1, 1'b1);
    exp_seq = {0, 0, 0, 1, 1};
    seq_chk("post_rst");
    reset_dut('0);
    for (int n = 0; n < 800; n++) begin
      en = (n >= 500) ? 4'($urandom) : '1;
      step(4'($urandom), $urandom_range(0, 3) != 0);
    end
    en = '1;
    repeat (8) step('0, 1'b1);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
